// File: rtl/tt_bist_pkg.sv
// Shared types and helpers for the pin loopback BIST: pattern modes,
// controller states and Fibonacci LFSR tap masks for widths 2..32.
package tt_bist_pkg;

    // Pattern selection after decoding the 2-bit mode input.
    typedef enum logic [1:0] {
        MODE_CNT  = 2'b00,
        MODE_WALK = 2'b01,
        MODE_PRBS = 2'b10
    } mode_e;

    // Controller states; the encoding is visible on the debug state port.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FLUSH = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // Mode 11 is not a pattern of its own and falls back to the counter.
    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'b01:   return MODE_WALK;
            2'b10:   return MODE_PRBS;
            default: return MODE_CNT;
        endcase
    endfunction

    // Maximal-length tap masks; bit (t-1) is set for polynomial term x^t.
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            2:       return 32'h0000_0003;
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0003;
        endcase
    endfunction

endpackage

// File: rtl/tt_bist_lfsr.sv
// Fibonacci LFSR pattern source. load restarts from the seed (zero seed is
// promoted to 1 so the register never locks up), step shifts one position.
module tt_bist_lfsr
    import tt_bist_pkg::*;
#(
    parameter int          WIDTH = 8,
    parameter logic [31:0] SEED  = 32'h0000_0001
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] TAPS   = WIDTH'(lfsr_taps(WIDTH));
    localparam logic [WIDTH-1:0] SEED_W = SEED[WIDTH-1:0];
    localparam logic [WIDTH-1:0] START  = (SEED_W == '0) ? WIDTH'(1) : SEED_W;

    logic feedback;

    assign feedback = ^(value & TAPS);

    // Shift left, feeding the XOR of the tapped bits into bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= START;
        end else if (step) begin
            value <= {value[WIDTH-2:0], feedback};
        end
    end

endmodule

// File: rtl/tt_pin_bist.sv
// Pin loopback BIST: drives counter / walking-one / PRBS vectors on pat_out,
// compares the looped-back rx_in one cycle later against the vector held in
// an expected register, and reports a saturating mismatch count.
module tt_pin_bist
    import tt_bist_pkg::*;
#(
    parameter int          WIDTH = 8,
    parameter int          ERR_W = 8,
    parameter logic [31:0] SEED  = 32'h0000_0001
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [7:0]       len,
    input  logic [WIDTH-1:0] rx_in,
    output logic [WIDTH-1:0] pat_out,
    output logic [WIDTH-1:0] pat_oe,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       state_dbg
);

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_e           state;
    state_e           next_state;
    mode_e            mode_q;
    logic [7:0]       len_q;
    logic [7:0]       idx;
    logic [WIDTH-1:0] vec;
    logic [WIDTH-1:0] vec_next;
    logic [WIDTH-1:0] pat_now;
    logic [WIDTH-1:0] exp_q;
    logic             exp_vld;
    logic             oe_q;
    logic             accept;
    logic             advance;
    logic             compare;
    logic             last;
    logic [WIDTH-1:0] lfsr_value;

    // len_q of 0 wraps to 255 here, which gives the 256-vector case for free.
    assign last = (idx == (len_q - 8'd1));

    tt_bist_lfsr #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .step  (advance && !last),
        .value (lfsr_value)
    );

    // State register; everything else in the FSM is combinational.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state plus the per-edge strobes; nothing moves while ena is low.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        advance    = 1'b0;
        compare    = 1'b0;
        if (ena) begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        next_state = ST_RUN;
                        accept     = 1'b1;
                    end
                end
                ST_RUN: begin
                    advance = 1'b1;
                    compare = exp_vld;
                    if (last) begin
                        next_state = ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    compare    = 1'b1;
                    next_state = ST_DONE;
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // Next counter or walking-one vector from the current one.
    always_comb begin
        vec_next = vec + WIDTH'(1);
        if (mode_q == MODE_WALK) begin
            vec_next = {vec[WIDTH-2:0], vec[WIDTH-1]};
        end
    end

    // Current vector source and the pin drive; pins are quiet in IDLE.
    always_comb begin
        pat_now = vec;
        if (mode_q == MODE_PRBS) begin
            pat_now = lfsr_value;
        end
        pat_out = (state == ST_IDLE) ? '0 : pat_now;
    end

    // Test datapath: latch config on start, step vectors, compare one behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_CNT;
            len_q   <= '0;
            idx     <= '0;
            vec     <= '0;
            exp_q   <= '0;
            exp_vld <= 1'b0;
            oe_q    <= 1'b0;
            err_cnt <= '0;
        end else begin
            if (accept) begin
                mode_q  <= decode_mode(mode);
                len_q   <= len;
                idx     <= '0;
                vec     <= (decode_mode(mode) == MODE_WALK) ? WIDTH'(1) : '0;
                exp_vld <= 1'b0;
                oe_q    <= 1'b1;
            end else if (advance) begin
                exp_q   <= pat_now;
                exp_vld <= 1'b1;
                if (last) begin
                    oe_q <= 1'b0;
                end else begin
                    idx <= idx + 8'd1;
                    vec <= vec_next;
                end
            end
            if (accept) begin
                err_cnt <= '0;
            end else if (compare && (rx_in != exp_q) && (err_cnt != ERR_MAX)) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
        end
    end

    assign pat_oe    = {WIDTH{oe_q}};
    assign busy      = (state == ST_RUN) || (state == ST_FLUSH);
    assign done      = (state == ST_DONE);
    assign pass      = done && (err_cnt == '0);
    assign state_dbg = state;

endmodule

// File: tb/tb_tt_pin_bist.sv
// Directed bench for tt_pin_bist: loopback runs in each pattern mode, stuck
// bit, enable freeze, mid-run reset, restart from DONE and error saturation.
module tb_tt_pin_bist;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic [1:0] mode;
    logic [7:0] len;
    logic [7:0] rx_in;
    logic [7:0] pat_out;
    logic [7:0] pat_oe;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_cnt;
    logic [1:0] state_dbg;

    logic       start_s;
    logic [1:0] mode_s;
    logic [7:0] len_s;
    logic [7:0] rx_s;
    logic [7:0] pat_out_s;
    logic [7:0] pat_oe_s;
    logic       busy_s;
    logic       done_s;
    logic       pass_s;
    logic [1:0] err_cnt_s;
    logic [1:0] state_dbg_s;

    logic [7:0] lb_q;
    int         rx_sel;
    int         n_checks = 0;
    int         n_errs   = 0;
    logic [7:0] exp_q[$];

    // Clock
    always #5 clk = ~clk;

    // Loopback wire: one enabled cycle of delay, optionally faulted.
    always_ff @(posedge clk) begin
        if (ena) lb_q <= pat_out;
    end

    always_comb begin
        case (rx_sel)
            1:       rx_in = lb_q & 8'hF7;
            2:       rx_in = 8'hFF;
            default: rx_in = lb_q;
        endcase
    end

    tt_pin_bist #(.WIDTH(8), .ERR_W(8), .SEED(32'h1)) u_dut (
        .clk (clk), .rst_n (rst_n), .ena (ena), .start (start), .mode (mode),
        .len (len), .rx_in (rx_in), .pat_out (pat_out), .pat_oe (pat_oe),
        .busy (busy), .done (done), .pass (pass), .err_cnt (err_cnt),
        .state_dbg (state_dbg)
    );

    tt_pin_bist #(.WIDTH(8), .ERR_W(2), .SEED(32'h1)) u_sat (
        .clk (clk), .rst_n (rst_n), .ena (ena), .start (start_s), .mode (mode_s),
        .len (len_s), .rx_in (rx_s), .pat_out (pat_out_s), .pat_oe (pat_oe_s),
        .busy (busy_s), .done (done_s), .pass (pass_s), .err_cnt (err_cnt_s),
        .state_dbg (state_dbg_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected vectors written from the pattern definitions.
    task automatic build_exp(input logic [1:0] m, input int n);
        logic [7:0] v;
        v = 8'h01;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            case (m)
                2'b01: exp_q.push_back(8'(1 << (k % 8)));
                2'b10: begin
                    exp_q.push_back(v);
                    v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
                end
                default: exp_q.push_back(8'(k));
            endcase
        end
    endtask

    // One full test: cycle 0 presents start, vectors appear in cycles 1..N,
    // FLUSH is cycle N+1, done in cycle N+2 (counted in enabled cycles).
    task automatic run_test(input logic [1:0] m, input logic [7:0] l, input int sel,
                            input int freeze_at, input int mid_start, input int exp_err);
        int         n;
        int         cyc;
        logic [7:0] last_vec;
        logic [7:0] hold_pat;
        logic [7:0] hold_err;
        logic [1:0] hold_st;
        n = (l == 8'd0) ? 256 : int'(l);
        build_exp(m, n);
        rx_sel = sel;
        @(negedge clk);
        start = 1'b1; mode = m; len = l;
        @(negedge clk);
        start = 1'b0; mode = 2'b00; len = 8'd1;
        cyc = 1;
        last_vec = 8'h00;
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_done_low", {31'd0, done}, 32'd0);
        while (done !== 1'b1 && cyc < 600) begin
            if (cyc <= n) begin
                check("oe_run", {24'd0, pat_oe}, 32'hFF);
                if (exp_q.size() == 0) check("extra_vec", {24'd0, pat_out}, 32'h100);
                else check("vec", {24'd0, pat_out}, {24'd0, exp_q.pop_front()});
                last_vec = pat_out;
            end else begin
                check("flush_oe", {24'd0, pat_oe}, 32'd0);
                check("flush_hold", {24'd0, pat_out}, {24'd0, last_vec});
                check("flush_busy", {31'd0, busy}, 32'd1);
            end
            start = (mid_start != 0 && cyc == mid_start);
            if (freeze_at != 0 && cyc == freeze_at) begin
                hold_pat = pat_out;
                hold_err = err_cnt;
                hold_st  = state_dbg;
                ena = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("frz_pat", {24'd0, pat_out}, {24'd0, hold_pat});
                    check("frz_err", {24'd0, err_cnt}, {24'd0, hold_err});
                    check("frz_state", {30'd0, state_dbg}, {30'd0, hold_st});
                end
                ena = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        check("done_cycle", cyc, n + 2);
        check("vec_left", exp_q.size(), 0);
        check("err_cnt", {24'd0, err_cnt}, exp_err);
        check("pass", {31'd0, pass}, (exp_err == 0) ? 32'd1 : 32'd0);
        check("busy_done", {31'd0, busy}, 32'd0);
        check("state_done", {30'd0, state_dbg}, 32'd3);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; mode = 2'b00; len = 8'd0; rx_sel = 0;
        start_s = 1'b0; mode_s = 2'b00; len_s = 8'd8; rx_s = 8'hFF;
        #12;
        check("rst_pat", {24'd0, pat_out}, 32'd0);
        check("rst_oe", {24'd0, pat_oe}, 32'd0);
        check("rst_flags", {29'd0, busy, done, pass}, 32'd0);
        check("rst_err", {24'd0, err_cnt}, 32'd0);
        check("rst_state", {30'd0, state_dbg}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Counter, len 4: vectors 0..3, done at cycle 6.
        run_test(2'b00, 8'd4, 0, 0, 0, 0);
        // Walking one, len 10, restarted straight from DONE; start in FLUSH ignored.
        run_test(2'b01, 8'd10, 0, 0, 11, 0);
        // PRBS, len 0 -> 256 vectors starting 01, done at cycle 258.
        run_test(2'b10, 8'd0, 0, 0, 0, 0);
        // Bit 3 stuck low over counter 0..15: vectors 8..15 fail.
        run_test(2'b00, 8'd16, 1, 0, 0, 8);
        repeat (3) @(negedge clk);
        check("done_hold", {31'd0, done}, 32'd1);
        check("err_hold", {24'd0, err_cnt}, 32'd8);
        // Mode 11 behaves as counter; start in RUN ignored.
        run_test(2'b11, 8'd5, 0, 0, 3, 0);
        // Enable dropped for 5 cycles mid-run: same result as without.
        run_test(2'b00, 8'd16, 1, 7, 0, 8);

        // Reset mid-run: after cycle 13, vectors 0..11 compared -> 4 errors.
        rx_sel = 1;
        @(negedge clk);
        start = 1'b1; mode = 2'b00; len = 8'd16;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        check("pre_rst_err", {24'd0, err_cnt}, 32'd4);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_pat", {24'd0, pat_out}, 32'd0);
        check("mid_rst_oe", {24'd0, pat_oe}, 32'd0);
        check("mid_rst_flags", {29'd0, busy, done, pass}, 32'd0);
        check("mid_rst_err", {24'd0, err_cnt}, 32'd0);
        check("mid_rst_state", {30'd0, state_dbg}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {30'd0, state_dbg}, 32'd0);
        run_test(2'b00, 8'd4, 0, 0, 0, 0);

        // ERR_W=2 instance, rx tied to FF over counter 0..7: saturates at 3.
        @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        cyc = 1;
        while (done_s !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("sat_done_cycle", cyc, 10);
        check("sat_err", {30'd0, err_cnt_s}, 32'd3);
        check("sat_pass", {31'd0, pass_s}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/tt_pin_bist.md
TT_PIN_BIST -- requirements
Module: tt_pin_bist

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the pattern and loopback bus width (2..32).
REQ-002 The block SHALL have parameter ERR_W, default 8, giving the error-counter width.
REQ-003 The block SHALL have parameter SEED, default 8'h01, giving the PRBS start value; a SEED of 0 SHALL be replaced by 1.
REQ-004 The block SHALL have port clk  input  1  as its single clock.
REQ-005 The block SHALL have port rst_n  input  1  as its asynchronous, active-low reset.
REQ-006 The block SHALL have port ena  input  1  as its enable; while low, all state freezes.
REQ-007 The block SHALL have port start  input  1  to request a test, sampled only in IDLE or DONE.
REQ-008 The block SHALL have port mode  input  2  to select the pattern: 00 counter, 01 walking-one, 10 PRBS, 11 treated as counter.
REQ-009 The block SHALL have port len  input  8  giving the vector count; 0 means 256.
REQ-010 The block SHALL have port rx_in  input  WIDTH  carrying the looped-back pattern.
REQ-011 The block SHALL have port pat_out  output  WIDTH  carrying the driven pattern.
REQ-012 The block SHALL have port pat_oe  output  WIDTH  as the output enable (all ones while driving).
REQ-013 The block SHALL have port busy  output  1  indicating the RUN or FLUSH state.
REQ-014 The block SHALL have port done  output  1  indicating results are valid.
REQ-015 The block SHALL have port pass  output  1  asserted when done and err_cnt == 0.
REQ-016 The block SHALL have port err_cnt  output  ERR_W  carrying the mismatch count, saturating at its maximum.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, RUN, FLUSH and DONE.
REQ-018 In IDLE or DONE, when start=1 and ena=1 at a clock edge, the FSM SHALL enter RUN and clear err_cnt, done and the vector index; mode and len SHALL be latched at that edge.
REQ-019 In RUN, cycle k (k=0..N-1, N=len or 256) SHALL present vector k on pat_out with pat_oe all ones.
REQ-020 Counter vectors SHALL be v(k)=k mod 2^WIDTH.
REQ-021 Walking-one vectors SHALL be v(k)=1<<(k mod WIDTH).
REQ-022 PRBS vectors SHALL be v(0)=SEED, with each next value the Fibonacci LFSR step of the previous; the WIDTH=8 polynomial SHALL be x^8+x^6+x^5+x^4+1.
REQ-023 Loopback latency SHALL be 1 cycle: at the edge ending cycle k+1, rx_in SHALL be compared bitwise against v(k) held in an expected register.
REQ-024 Any bit mismatch SHALL count as one error; err_cnt SHALL increment by 1 and hold at 2^ERR_W-1.
REQ-025 After vector N-1 the FSM SHALL enter FLUSH for one cycle to perform the final compare; during FLUSH pat_oe SHALL be 0 and pat_out SHALL hold its last value.
REQ-026 FLUSH SHALL go to DONE: done=1 and busy=0, with results held until the next accepted start.
REQ-027 done SHALL first assert exactly N+2 enabled cycles after start is accepted.
REQ-028 start SHALL be ignored in RUN and FLUSH.
REQ-029 A start accepted in DONE SHALL restart a test directly, with done dropping at the same edge.
REQ-030 With ena=0, the FSM, vector index, expected register and err_cnt SHALL hold, and no compare SHALL occur.
REQ-031 On resuming, a compare SHALL use rx_in sampled at the next enabled edge.
REQ-032 In IDLE, pat_out SHALL be 0 and pat_oe SHALL be 0.

Reset
REQ-033 rst_n low SHALL asynchronously force state IDLE and pat_out, pat_oe, busy, done, pass, err_cnt, the index and the expected register all to 0.
REQ-034 Reset deassertion SHALL be synchronised externally; an in-flight test SHALL be abandoned by reset, with no partial results retained.

Structure
REQ-035 Package tt_bist_pkg SHALL hold the mode and state enums and a function returning LFSR tap masks per WIDTH (2..32).
REQ-036 The LFSR SHALL be a sub-module tt_bist_lfsr (parameters WIDTH and SEED; ports load, step, value).

Verification
REQ-037 Scenario: rx_in=pat_out delayed 1 cycle, mode=00, len=4 -> pat_out 0,1,2,3; done at cycle 6; pass=1; err_cnt=0.
REQ-038 Scenario: mode=01, len=10, WIDTH=8, ideal loopback -> pat_out 01,02,04,...,80,01,02; pass=1.
REQ-039 Scenario: mode=10, len=0, ideal loopback -> 256 vectors; first vector 01; done at cycle 258; pass=1.
REQ-040 Scenario: rx_in bit 3 stuck at 0, mode=00, len=16 -> err_cnt=8; pass=0.
REQ-041 Scenario: ERR_W=2, rx_in tied to FF, mode=00, len=8 -> err_cnt saturates at 3.
REQ-042 Scenario: ena low for 5 cycles mid-RUN, then rst_n low during RUN -> freeze with the same final results; reset gives all outputs 0 and IDLE, and the next start runs cleanly.
